// File: rtl/store_commit_unit.sv
// store_commit_unit: drains ROB-committed stores to memory in queue order, one write in flight.
// Optional STQ_COMMIT_TIMEOUT_EN: re-issue the request after TIMEOUT_CYCLES unacknowledged WAIT_ACK cycles.
module store_commit_unit #(
  parameter int STQ_SIZE       = 8,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [STQ_SIZE-1:0]         stq_valid,
  input  logic [STQ_SIZE-1:0]         stq_rob_committed,
  input  logic [STQ_SIZE*XLEN-1:0]    stq_address,
  input  logic [STQ_SIZE*XLEN-1:0]    stq_data,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [XLEN-1:0]             mem_req_address,
  output logic [XLEN-1:0]             mem_req_data,
  input  logic                        mem_resp_valid,
  output logic                        stq_commit_valid,
  output logic [$clog2(STQ_SIZE)-1:0] stq_commit_index,
  output logic [$clog2(STQ_SIZE)-1:0] commit_ptr,
  output logic                        busy,
  output logic                        timeout_error
);
  localparam int IW = $clog2(STQ_SIZE);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, COMMIT} state_t;
  state_t state, state_nx;
  logic [IW-1:0]   idx_q;
  logic [XLEN-1:0] addr_q, data_q, head_addr, head_data;
  logic            eligible, to_hit;
  // only the head entry is ever considered, which keeps commits in program order
  assign eligible  = stq_valid[commit_ptr] && stq_rob_committed[commit_ptr];
  assign head_addr = stq_address[commit_ptr*XLEN +: XLEN];
  assign head_data = stq_data[commit_ptr*XLEN +: XLEN];
`ifdef STQ_COMMIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) to_cnt <= '0;
    else to_cnt <= (state == WAIT_ACK && !mem_resp_valid) ? to_cnt + 1'b1 : '0;
  // a response arriving on the limit cycle wins over the timeout
  assign to_hit = state == WAIT_ACK && !mem_resp_valid && to_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = eligible ? REQ : IDLE;
      REQ:      state_nx = mem_req_ready ? WAIT_ACK : REQ;
      WAIT_ACK: state_nx = mem_resp_valid ? COMMIT : (to_hit ? REQ : WAIT_ACK);
      COMMIT:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      commit_ptr <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && eligible) begin
        idx_q  <= commit_ptr;
        addr_q <= head_addr;
        data_q <= head_data;
      end
      if (state == COMMIT) commit_ptr <= commit_ptr + 1'b1;
    end
  assign mem_req_valid    = state == REQ;
  assign mem_req_address  = addr_q;
  assign mem_req_data     = data_q;
  assign stq_commit_valid = state == COMMIT;
  assign stq_commit_index = idx_q;
  assign busy             = state != IDLE;
  assign timeout_error    = to_hit;
endmodule

// File: tb/tb_store_commit_unit.sv
// tb_store_commit_unit: directed checks of ordering, stalls, wrap-around, reset and timeout re-issue.
module tb_store_commit_unit;
  logic          clk = 0, reset = 1;
  logic [7:0]    stq_valid = 0, stq_rob_committed = 0;
  logic [255:0]  stq_address = 0, stq_data = 0;
  logic          mem_req_valid, mem_req_ready = 0, mem_resp_valid = 0;
  logic [31:0]   mem_req_address, mem_req_data;
  logic          stq_commit_valid, busy, timeout_error;
  logic [2:0]    stq_commit_index, commit_ptr;
  int            tests = 0, fails = 0;
  logic          seen;
  store_commit_unit #(.STQ_SIZE(8), .XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .stq_valid(stq_valid), .stq_rob_committed(stq_rob_committed),
    .stq_address(stq_address), .stq_data(stq_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_address(mem_req_address), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .stq_commit_valid(stq_commit_valid),
    .stq_commit_index(stq_commit_index), .commit_ptr(commit_ptr), .busy(busy),
    .timeout_error(timeout_error)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    stq_valid = 0; stq_rob_committed = 0; mem_req_ready = 0; mem_resp_valid = 0;
    tick();
    reset = 0;
    tick();
  endtask
  task automatic set_entry(input int i, input logic [31:0] a, input logic [31:0] d);
    stq_address[i*32 +: 32] = a;
    stq_data[i*32 +: 32]    = d;
  endtask
  // called in IDLE with the head entry eligible; walks the minimum-latency path
  task automatic do_store(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
    chk("idle_busy", busy, 0);
    mem_req_ready = 1;
    tick();
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_address, a);
    chk("req_data", mem_req_data, d);
    tick();
    chk("wait_req_low", mem_req_valid, 0);
    mem_resp_valid = 1;
    tick();
    chk("commit_valid", stq_commit_valid, 1);
    chk("commit_index", stq_commit_index, i);
    mem_resp_valid = 0;
    tick();
    chk("commit_pulse_once", stq_commit_valid, 0);
    chk("commit_ptr_inc", commit_ptr, 3'(i + 3'd1));
  endtask
  initial begin
    do_reset();
    chk("rst_ptr", commit_ptr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_commit", stq_commit_valid, 0);
    chk("rst_addr", mem_req_address, 0);
    chk("rst_timeout", timeout_error, 0);
    // single store, minimum latency
    set_entry(0, 32'h1000, 32'hDEADBEEF);
    stq_valid = 8'h01; stq_rob_committed = 8'h01;
    do_store(3'd0, 32'h1000, 32'hDEADBEEF);
    stq_valid = 0; stq_rob_committed = 0;
    tick();
    chk("empty_idle", busy, 0);
    // two stores with a 4-cycle ready stall; latched request must not move
    do_reset();
    set_entry(0, 32'h2000, 32'h11111111);
    set_entry(1, 32'h2004, 32'h22222222);
    stq_valid = 8'h03; stq_rob_committed = 8'h03;
    tick();
    set_entry(0, 32'hBAD0, 32'hBADBAD00);
    stq_rob_committed = 8'h02;
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_address, 32'h2000);
      chk("stall_data", mem_req_data, 32'h11111111);
      tick();
    end
    mem_req_ready = 1;
    mem_resp_valid = 1;
    tick();
    chk("handshake_resp_ignored", stq_commit_valid, 0);
    chk("wait_busy", busy, 1);
    tick();
    chk("stall_commit_valid", stq_commit_valid, 1);
    chk("stall_commit_index", stq_commit_index, 0);
    mem_resp_valid = 0;
    tick();
    chk("b2b_idle_gap", mem_req_valid, 0);
    do_store(3'd1, 32'h2004, 32'h22222222);
    // head not ROB-committed blocks a younger committed store
    do_reset();
    set_entry(0, 32'h3000, 32'h30303030);
    set_entry(1, 32'h3004, 32'h31313131);
    stq_valid = 8'h03; stq_rob_committed = 8'h02; mem_req_ready = 1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      seen |= mem_req_valid;
      tick();
    end
    chk("blocked_no_req", seen, 0);
    stq_rob_committed = 8'h03;
    do_store(3'd0, 32'h3000, 32'h30303030);
    do_store(3'd1, 32'h3004, 32'h31313131);
    // wrap-around: advance to entry 7, then commit 7 and 0
    do_reset();
    for (int k = 0; k < 8; k++) set_entry(k, 32'h4000 + 32'(k * 4), 32'hA0 + 32'(k));
    stq_valid = 8'hFF; stq_rob_committed = 8'hFF;
    for (int k = 0; k < 7; k++) do_store(3'(k), 32'h4000 + 32'(k * 4), 32'hA0 + 32'(k));
    chk("ptr_at_7", commit_ptr, 7);
    do_store(3'd7, 32'h401C, 32'hA7);
    chk("ptr_wrapped", commit_ptr, 0);
    do_store(3'd0, 32'h4000, 32'hA0);
    stq_valid = 0;
    // asynchronous reset in WAIT_ACK, then a stale response
    do_reset();
    set_entry(0, 32'h5000, 32'h55555555);
    stq_valid = 8'h01; stq_rob_committed = 8'h01; mem_req_ready = 1;
    tick();
    tick();
    chk("pre_rst_wait", busy, 1);
    #2 reset = 1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_addr", mem_req_address, 0);
    chk("async_rst_data", mem_req_data, 0);
    stq_valid = 0;
    tick();
    reset = 0;
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    chk("stale_resp_commit", stq_commit_valid, 0);
    chk("stale_resp_busy", busy, 0);
    chk("stale_resp_ptr", commit_ptr, 0);
    // response withheld in WAIT_ACK
    set_entry(0, 32'h6000, 32'h66666666);
    stq_valid = 8'h01; stq_rob_committed = 8'h01; mem_req_ready = 1;
    tick();
    chk("to_req", mem_req_valid, 1);
    tick();
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      seen |= timeout_error;
      tick();
    end
    chk("to_early", seen, 0);
`ifdef STQ_COMMIT_TIMEOUT_EN
    chk("to_pulse", timeout_error, 1);
    tick();
    chk("to_single", timeout_error, 0);
    chk("to_reissue", mem_req_valid, 1);
    chk("to_reissue_addr", mem_req_address, 32'h6000);
    chk("to_reissue_data", mem_req_data, 32'h66666666);
    tick();
`else
    for (int k = 0; k < 10; k++) begin
      seen |= timeout_error | mem_req_valid | stq_commit_valid;
      tick();
    end
    chk("no_timeout", seen, 0);
`endif
    chk("to_wait_busy", busy, 1);
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    chk("to_commit", stq_commit_valid, 1);
    chk("to_commit_idx", stq_commit_index, 0);
    stq_valid = 0;
    tick();
    chk("to_commit_once", stq_commit_valid, 0);
    chk("to_ptr", commit_ptr, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_commit_unit.md
Name: store_commit_unit

Overview:
- Drains ROB-committed stores from the store queue to memory in program order.
- Owns the store-queue commit pointer.
- Produces the `stq_commit_valid` / `stq_commit_index` pulse consumed by the LSU order failure detector and by store-queue entry deallocation.
- Sits between the store queue and the data-memory write port; one write outstanding at a time.

Parameters:
- STQ_SIZE, 8, number of store queue entries; power of two, ≥2.
- XLEN, 32, address and data width.
- TIMEOUT_CYCLES, 64, WAIT_ACK cycles before re-issue; used only with STQ_COMMIT_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- stq_valid  input  STQ_SIZE  entry holds a store
- stq_rob_committed  input  STQ_SIZE  ROB has retired the store in this entry
- stq_address  input  STQ_SIZE*XLEN  per-entry address; entry i at bits [i*XLEN +: XLEN]
- stq_data  input  STQ_SIZE*XLEN  per-entry store data, same packing
- mem_req_valid  output  1  write request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_address  output  XLEN  write address
- mem_req_data  output  XLEN  write data
- mem_resp_valid  input  1  write acknowledge
- stq_commit_valid  output  1  one-cycle pulse: store at stq_commit_index is globally visible
- stq_commit_index  output  $clog2(STQ_SIZE)  index of the committing store
- commit_ptr  output  $clog2(STQ_SIZE)  oldest uncommitted entry (store queue head)
- busy  output  1  state != IDLE
- timeout_error  output  1  one-cycle pulse on timeout; tied 0 without macro

Behaviour:
Reset (asynchronous, any state):
- state=IDLE, commit_ptr=0.
- Latched index/address/data = 0.
- All outputs 0.
- An in-flight request is abandoned; a late mem_resp_valid after reset is ignored in IDLE.

FSM (one register, four states):
- IDLE:
  - If stq_valid[commit_ptr] && stq_rob_committed[commit_ptr]: latch commit_ptr, stq_address[commit_ptr], stq_data[commit_ptr]; go to REQ.
  - Otherwise stay.
  - Entries other than commit_ptr are never examined (strict order).
- REQ:
  - mem_req_valid=1; address/data driven from latches, stable until handshake.
  - On mem_req_valid && mem_req_ready go to WAIT_ACK.
  - Valid is never withdrawn before the handshake.
- WAIT_ACK:
  - mem_req_valid=0.
  - On mem_resp_valid go to COMMIT.
  - mem_resp_valid in any other state is ignored.
  - mem_resp_valid in the same cycle as the REQ handshake is ignored.
- COMMIT:
  - stq_commit_valid=1 for exactly this cycle; stq_commit_index = latched index.
  - commit_ptr <= commit_ptr+1, modulo STQ_SIZE (wrap-around from STQ_SIZE-1 to 0).
  - Go to IDLE.

Ordering and timing:
- stq_commit_index holds the latched index in all states; it is meaningful only while stq_commit_valid=1.
- The detector sees exactly one commit pulse per store, in queue order.
- Minimum latency, eligibility to commit pulse: 3 cycles (eligible seen in IDLE at T, REQ at T+1 with ready, WAIT_ACK at T+2 with resp, COMMIT at T+3).
- Back-to-back stores: next REQ no earlier than T+5. IDLE re-evaluates the incremented commit_ptr at T+4.

Boundary conditions:
- Empty queue (stq_valid[commit_ptr]=0): stays IDLE, no memory traffic.
- stq_rob_committed deasserted after the latch: no effect; committed stores are never squashed.
- stq_address / stq_data changes after the latch: no effect on the request.
- Full queue: no special handling; ordering is by commit_ptr only.

Optional Feature:
STQ_COMMIT_TIMEOUT_EN
- Defined:
  - Counter of $clog2(TIMEOUT_CYCLES+1) bits, cleared on entry to WAIT_ACK, increments each WAIT_ACK cycle without mem_resp_valid.
  - On reaching TIMEOUT_CYCLES: timeout_error pulses for 1 cycle and the FSM returns to REQ, re-issuing the same latched address/data.
  - mem_resp_valid in the same cycle as the limit wins: go to COMMIT, no timeout.
- Undefined: no counter; WAIT_ACK waits indefinitely; timeout_error tied 0.

Test Plan:
- Reset then stq_valid=0x01, stq_rob_committed=0x01, addr[0]=0x1000, data[0]=0xDEADBEEF, ready=1, resp the cycle after handshake -> mem_req at T+1 with 0x1000/0xDEADBEEF; stq_commit_valid=1 and index=0 at T+3; commit_ptr=1 after.
- Entries 0 and 1 committed; ready low 4 cycles in REQ -> mem_req_valid held with stable addr/data; commits in order index 0 then 1; second REQ no earlier than 5 cycles after first.
- Entry 1 committed, entry 0 valid but not ROB-committed -> no mem_req_valid for 20 cycles; set stq_rob_committed[0] -> entry 0 then 1 commit.
- Start with commit_ptr=7 (commit 7 stores), commit entries 7 and 0 -> stq_commit_index 7 then 0; commit_ptr wraps 7→0→1.
- Assert reset during WAIT_ACK, then mem_resp_valid -> outputs 0, commit_ptr=0, no stq_commit_valid pulse.
- STQ_COMMIT_TIMEOUT_EN, TIMEOUT_CYCLES=4, resp withheld -> timeout_error pulse after 4 WAIT_ACK cycles; same request re-issued; a later resp yields a single commit pulse.
